// File: rtl/multi_cycle_seq_if.sv
// Control bundle between the multi-cycle sequencer and its datapath / memory ports.
// The sequencer uses the slave modport; the environment driving INSTR and the RDYs uses master.
interface multi_cycle_seq_if;
    logic [31:0] INSTR;
    logic        I_MEM_RDY;
    logic        D_MEM_RDY;
    logic        BR_TAKEN;
    logic [2:0]  STATE;
    logic        I_MEM_REQ;
    logic        IR_WE;
    logic        PC_WE;
    logic [1:0]  PC_SRC;
    logic        D_MEM_REQ;
    logic        D_MEM_WEN;
    logic        RF_WE;
    logic [1:0]  WB_SEL;
    logic        HALT;
    logic [31:0] NUM_INST;

    modport slave (
        input  INSTR, I_MEM_RDY, D_MEM_RDY, BR_TAKEN,
        output STATE, I_MEM_REQ, IR_WE, PC_WE, PC_SRC, D_MEM_REQ, D_MEM_WEN,
        output RF_WE, WB_SEL, HALT, NUM_INST
    );

    modport master (
        output INSTR, I_MEM_RDY, D_MEM_RDY, BR_TAKEN,
        input  STATE, I_MEM_REQ, IR_WE, PC_WE, PC_SRC, D_MEM_REQ, D_MEM_WEN,
        input  RF_WE, WB_SEL, HALT, NUM_INST
    );
endinterface

// File: rtl/multi_cycle_seq.sv
// RV32I multi-cycle sequencer: steps IF/ID/EX/MEM/WB, emits datapath strobes,
// stalls on memory ready handshakes, counts retirements and halts on ECALL/illegal opcode.
module multi_cycle_seq #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic              CLK,
    input  logic              RST,
    multi_cycle_seq_if.slave  bus
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic [2:0]  r_state;
    logic [31:0] r_num_inst;

    logic [2:0]  w_state_nxt;
    logic        w_i_mem_req;
    logic        w_ir_we;
    logic        w_pc_we;
    logic [1:0]  w_pc_src;
    logic        w_d_mem_req;
    logic        w_d_mem_wen;
    logic        w_rf_we;
    logic [1:0]  w_wb_sel;

    logic [6:0]  w_opcode;
    logic        w_rd_nz;
    logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic        w_is_load, w_is_store, w_is_opimm, w_is_op;
    logic        w_legal;

    assign w_opcode    = bus.INSTR[6:0];
    assign w_rd_nz     = |bus.INSTR[11:7];
    assign w_is_lui    = (w_opcode == OP_LUI);
    assign w_is_auipc  = (w_opcode == OP_AUIPC);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jalr   = (w_opcode == OP_JALR);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_opimm  = (w_opcode == OP_OPIMM);
    assign w_is_op     = (w_opcode == OP_OP);
    assign w_legal     = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                         w_is_load | w_is_store | w_is_opimm | w_is_op;

    // Strobes are forced idle while RST is high so nothing escapes during an abort.
    always_comb begin
        w_state_nxt = r_state;
        w_i_mem_req = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = 2'd0;
        w_d_mem_req = 1'b0;
        w_d_mem_wen = 1'b1;
        w_rf_we     = 1'b0;
        w_wb_sel    = 2'd0;
        if (!RST) begin
            case (r_state)
                S_IF: begin
                    w_i_mem_req = 1'b1;
                    if (bus.I_MEM_RDY) begin
                        w_ir_we     = 1'b1;
                        w_state_nxt = S_ID;
                    end
                end
                S_ID: begin
                    if (bus.INSTR == ECALL || !w_legal) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_EX;
                    end
                end
                S_EX: begin
                    if (w_is_branch) begin
                        w_pc_we     = 1'b1;
                        w_pc_src    = bus.BR_TAKEN ? 2'd1 : 2'd0;
                        w_state_nxt = S_IF;
                    end else if (w_is_load || w_is_store) begin
                        w_state_nxt = S_MEM;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
                S_MEM: begin
                    w_d_mem_req = 1'b1;
                    w_d_mem_wen = ~w_is_store;
                    if (bus.D_MEM_RDY) begin
                        if (w_is_store) begin
                            w_pc_we     = 1'b1;
                            w_state_nxt = S_IF;
                        end else begin
                            w_state_nxt = S_WB;
                        end
                    end
                end
                S_WB: begin
                    w_rf_we     = w_rd_nz;
                    w_pc_we     = 1'b1;
                    w_state_nxt = S_IF;
                    if (w_is_jal) begin
                        w_pc_src = 2'd1;
                    end else if (w_is_jalr) begin
                        w_pc_src = 2'd2;
                    end
                    // AUIPC and OP/OP-IMM leave WB_SEL at ALU.
                    if (w_is_load) begin
                        w_wb_sel = 2'd1;
                    end else if (w_is_jal || w_is_jalr) begin
                        w_wb_sel = 2'd2;
                    end else if (w_is_lui) begin
                        w_wb_sel = 2'd3;
                    end
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = RESET_STATE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= RESET_STATE;
            r_num_inst <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_we) begin
                r_num_inst <= r_num_inst + 32'd1;
            end
        end
    end

    assign bus.STATE     = r_state;
    assign bus.I_MEM_REQ = w_i_mem_req;
    assign bus.IR_WE     = w_ir_we;
    assign bus.PC_WE     = w_pc_we;
    assign bus.PC_SRC    = w_pc_src;
    assign bus.D_MEM_REQ = w_d_mem_req;
    assign bus.D_MEM_WEN = w_d_mem_wen;
    assign bus.RF_WE     = w_rf_we;
    assign bus.WB_SEL    = w_wb_sel;
    assign bus.HALT      = (r_state == S_HALT);
    assign bus.NUM_INST  = r_num_inst;

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Self-checking bench for multi_cycle_seq: directed vector table, hand-written reset
// sequences, and randomized instructions/wait states against a per-instruction reference model.
module tb_multi_cycle_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_cycle_seq_if bus_if ();

    multi_cycle_seq #(.RESET_STATE(3'd0)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    typedef struct {
        int          cycles;
        logic [63:0] trace;
        int          ireq;
        int          irwe;
        int          dreq;
        int          wen_low;
        int          rf;
        int          pcwe;
        logic [1:0]  pcsrc;
        logic [1:0]  wbsel;
        logic        halted;
        logic        stray;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        int          iw;
        int          dw;
        logic        br;
        int          cyc;
        logic [1:0]  pcsrc;
        logic [1:0]  wbsel;
        int          rf;
        logic        halt;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int ninst    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every strobe other than HALT, with D_MEM_WEN inverted so idle reads as all-zero.
    function automatic logic [10:0] strobes();
        return {bus_if.I_MEM_REQ, bus_if.IR_WE, bus_if.PC_WE, bus_if.PC_SRC, bus_if.D_MEM_REQ,
                ~bus_if.D_MEM_WEN, bus_if.RF_WE, bus_if.WB_SEL, 1'b0};
    endfunction

    // Reference: expected behaviour of one instruction derived from the stage rules.
    function automatic obs_t model(input logic [31:0] instr, input int iw, input int dw,
                                   input logic br);
        obs_t        e;
        logic [6:0]  op;
        logic        lui, auipc, jal, jalr, brn, ld, st, legal, wr_rd;
        e  = '{default: 0};
        op = instr[6:0];
        lui   = (op == 7'h37);
        auipc = (op == 7'h17);
        jal   = (op == 7'h6F);
        jalr  = (op == 7'h67);
        brn   = (op == 7'h63);
        ld    = (op == 7'h03);
        st    = (op == 7'h23);
        legal = lui | auipc | jal | jalr | brn | ld | st | (op == 7'h13) | (op == 7'h33);
        for (int i = 0; i <= iw; i++) begin
            e.trace = {e.trace[60:0], 3'd0};
            e.cycles++;
        end
        e.ireq = iw + 1;
        e.irwe = 1;
        e.trace = {e.trace[60:0], 3'd1};
        e.cycles++;
        if (!legal || instr == 32'h73) begin
            e.trace  = {e.trace[60:0], 3'd5};
            e.cycles++;
            e.halted = 1'b1;
            return e;
        end
        e.trace = {e.trace[60:0], 3'd2};
        e.cycles++;
        e.pcwe  = 1;
        e.pcsrc = brn ? {1'b0, br} : jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
        if (brn) return e;
        if (ld || st) begin
            for (int i = 0; i <= dw; i++) begin
                e.trace = {e.trace[60:0], 3'd3};
                e.cycles++;
            end
            e.dreq    = dw + 1;
            e.wen_low = st ? dw + 1 : 0;
            if (st) return e;
        end
        e.trace = {e.trace[60:0], 3'd4};
        e.cycles++;
        wr_rd   = (instr[11:7] != 5'd0);
        e.rf    = wr_rd ? 1 : 0;
        e.wbsel = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
        return e;
    endfunction

    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic br, output obs_t o);
        int         ic = 0;
        int         dc = 0;
        logic [2:0] st;
        logic       done = 1'b0;
        o = '{default: 0};
        bus_if.INSTR    = instr;
        bus_if.BR_TAKEN = br;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            st = bus_if.STATE;
            // RDY outside its own request state is random noise that must be ignored.
            bus_if.I_MEM_RDY = (st == 3'd0) ? (ic >= iw) : 1'($urandom_range(0, 1));
            bus_if.D_MEM_RDY = (st == 3'd3) ? (dc >= dw) : 1'($urandom_range(0, 1));
            if (st == 3'd0) ic++;
            if (st == 3'd3) dc++;
            #1;
            o.cycles++;
            o.trace = {o.trace[60:0], st};
            if (bus_if.I_MEM_REQ) o.ireq++;
            if (bus_if.IR_WE) o.irwe++;
            if (bus_if.D_MEM_REQ) o.dreq++;
            if (bus_if.D_MEM_REQ && !bus_if.D_MEM_WEN) o.wen_low++;
            if (bus_if.RF_WE) begin
                o.rf++;
                o.wbsel = bus_if.WB_SEL;
            end
            if (bus_if.PC_WE) begin
                o.pcwe++;
                o.pcsrc = bus_if.PC_SRC;
                done    = 1'b1;
            end
            if (st == 3'd5) begin
                o.halted = bus_if.HALT;
                o.stray  = (strobes() != 11'd0);
                done     = 1'b1;
            end
        end
        if (!done) check("instr_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, ".cycles"}, 64'(o.cycles), 64'(e.cycles));
        check({tag, ".trace"}, o.trace, e.trace);
        check({tag, ".ireq"}, 64'(o.ireq), 64'(e.ireq));
        check({tag, ".irwe"}, 64'(o.irwe), 64'(e.irwe));
        check({tag, ".dreq"}, 64'(o.dreq), 64'(e.dreq));
        check({tag, ".wen_low"}, 64'(o.wen_low), 64'(e.wen_low));
        check({tag, ".rf_we"}, 64'(o.rf), 64'(e.rf));
        check({tag, ".pc_we"}, 64'(o.pcwe), 64'(e.pcwe));
        check({tag, ".halt"}, 64'(o.halted), 64'(e.halted));
        check({tag, ".halt_strobes"}, 64'(o.stray), 64'd0);
        if (e.pcwe != 0) check({tag, ".pc_src"}, 64'(o.pcsrc), 64'(e.pcsrc));
        if (e.rf != 0) check({tag, ".wb_sel"}, 64'(o.wbsel), 64'(e.wbsel));
    endtask

    // Retire-count check after the instruction's final edge, or at once for a halt.
    task automatic check_count(input string tag, input obs_t o);
        if (!o.halted) begin
            ninst++;
            @(posedge clk);
            #1;
        end
        check({tag, ".num_inst"}, 64'(bus_if.NUM_INST), 64'(ninst));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.INSTR     = 32'h0;
        bus_if.I_MEM_RDY = 1'b1;
        bus_if.D_MEM_RDY = 1'b1;
        bus_if.BR_TAKEN  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.strobes_idle", 64'(strobes()), 64'd0);
        check("rst.halt", 64'(bus_if.HALT), 64'd0);
        bus_if.I_MEM_RDY = 1'b0;
        bus_if.D_MEM_RDY = 1'b0;
        rst = 1'b0;
        #1;
        check("rst.state", 64'(bus_if.STATE), 64'd0);
        check("rst.i_mem_req", 64'(bus_if.I_MEM_REQ), 64'd1);
        check("rst.other_strobes", 64'(strobes()), 64'h400);
        check("rst.num_inst", 64'(bus_if.NUM_INST), 64'd0);
        ninst = 0;
    endtask

    vec_t vecs[11];

    initial begin
        obs_t        o;
        obs_t        e;
        logic [31:0] instr;
        logic [6:0]  op;
        logic [6:0]  legal_ops[9];
        bit          found;

        vecs[0]  = '{32'h00500093, 0, 0, 1'b0, 4, 2'd0, 2'd0, 1, 1'b0}; // ADDI x1,x0,5
        vecs[1]  = '{32'h0000A103, 0, 2, 1'b0, 7, 2'd0, 2'd1, 1, 1'b0}; // LW, RDY on 3rd MEM
        vecs[2]  = '{32'h0020A023, 0, 0, 1'b0, 4, 2'd0, 2'd0, 0, 1'b0}; // SW
        vecs[3]  = '{32'h00208463, 0, 0, 1'b1, 3, 2'd1, 2'd0, 0, 1'b0}; // BEQ taken
        vecs[4]  = '{32'h00208463, 0, 0, 1'b0, 3, 2'd0, 2'd0, 0, 1'b0}; // BEQ not taken
        vecs[5]  = '{32'h00008067, 0, 0, 1'b0, 4, 2'd2, 2'd0, 0, 1'b0}; // JALR x0,0(x1)
        vecs[6]  = '{32'h008000EF, 0, 0, 1'b0, 4, 2'd1, 2'd2, 1, 1'b0}; // JAL x1,8
        vecs[7]  = '{32'h000012B7, 2, 0, 1'b0, 6, 2'd0, 2'd3, 1, 1'b0}; // LUI x5, 2 fetch waits
        vecs[8]  = '{32'h00000197, 0, 0, 1'b0, 4, 2'd0, 2'd0, 1, 1'b0}; // AUIPC x3
        vecs[9]  = '{32'h0020A023, 1, 1, 1'b0, 6, 2'd0, 2'd0, 0, 1'b0}; // SW with waits
        vecs[10] = '{32'h00000073, 0, 0, 1'b0, 3, 2'd0, 2'd0, 0, 1'b1}; // ECALL

        legal_ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].instr, vecs[i].iw, vecs[i].dw, vecs[i].br, o);
            check($sformatf("vec%0d.cycles", i), 64'(o.cycles), 64'(vecs[i].cyc));
            check($sformatf("vec%0d.halt", i), 64'(o.halted), 64'(vecs[i].halt));
            check($sformatf("vec%0d.rf_we", i), 64'(o.rf), 64'(vecs[i].rf));
            if (!vecs[i].halt) check($sformatf("vec%0d.pc_src", i), 64'(o.pcsrc),
                                     64'(vecs[i].pcsrc));
            if (vecs[i].rf != 0) check($sformatf("vec%0d.wb_sel", i), 64'(o.wbsel),
                                       64'(vecs[i].wbsel));
            compare($sformatf("vec%0d", i), o, model(vecs[i].instr, vecs[i].iw, vecs[i].dw,
                                                     vecs[i].br));
            check_count($sformatf("vec%0d", i), o);
        end

        // HALT is sticky regardless of RDY noise.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.I_MEM_RDY = 1'($urandom_range(0, 1));
            bus_if.D_MEM_RDY = 1'($urandom_range(0, 1));
            #1;
            check("halt_sticky.state", 64'(bus_if.STATE), 64'd5);
            check("halt_sticky.halt", 64'(bus_if.HALT), 64'd1);
            check("halt_sticky.num_inst", 64'(bus_if.NUM_INST), 64'(ninst));
        end

        // Illegal opcode after a fresh reset.
        do_reset();
        run_instr(32'h0000007F, 1, 0, 1'b0, o);
        compare("illegal", o, model(32'h0000007F, 1, 0, 1'b0));
        check_count("illegal", o);

        // RST while a load waits in MEM aborts immediately.
        do_reset();
        bus_if.INSTR     = 32'h0000A103;
        bus_if.I_MEM_RDY = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            @(negedge clk);
            if (bus_if.STATE == 3'd3) found = 1'b1;
        end
        check("mem_abort.reached_mem", 64'(found), 64'd1);
        check("mem_abort.d_mem_req", 64'(bus_if.D_MEM_REQ), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mem_abort.state", 64'(bus_if.STATE), 64'd0);
        check("mem_abort.strobes", 64'(strobes()), 64'd0);
        bus_if.D_MEM_RDY = 1'b1;
        @(posedge clk);
        #1;
        check("mem_abort.no_pc_we", 64'(bus_if.PC_WE), 64'd0);
        check("mem_abort.no_rf_we", 64'(bus_if.RF_WE), 64'd0);
        check("mem_abort.num_inst", 64'(bus_if.NUM_INST), 64'd0);
        do_reset();

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 200; n++) begin
            int   iw;
            int   dw;
            int   pick;
            logic br;
            iw   = int'($urandom_range(0, 3));
            dw   = int'($urandom_range(0, 4));
            br   = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 39));
            instr = $urandom;
            if (pick == 0) begin
                instr = 32'h00000073;
            end else if (pick == 1) begin
                do begin
                    op    = 7'($urandom_range(0, 127));
                    found = 1'b0;
                    for (int k = 0; k < 9; k++) if (legal_ops[k] == op) found = 1'b1;
                end while (found);
                instr[6:0] = op;
            end else begin
                instr[6:0] = legal_ops[pick % 9];
            end
            run_instr(instr, iw, dw, br, o);
            e = model(instr, iw, dw, br);
            compare($sformatf("rnd%0d_%08h", n, instr), o, e);
            check_count($sformatf("rnd%0d", n), o);
            if (o.halted || e.halted) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
